// File: rtl/enc_cw_formatter_pkg.sv
// -----------------------------------------------------------------------------
// encoder_pkg
// Shared constants and types for the RS encoder codeword formatter.
//   EGF_DIM        bits per GF symbol
//   ENC_SYM        symbols per output beat
//   ENC_MES_LEN    message symbols per codeword (multiple of ENC_SYM)
//   ENC_PAR_LEN    parity symbols per codeword (multiple of ENC_SYM)
//   ENC_MES_BEATS / ENC_PAR_BEATS   beats per codeword section
//   egf_sym_t      one GF symbol
//   enc_cwf_state_t formatter FSM state {MES, PAR}
// -----------------------------------------------------------------------------
package encoder_pkg;

  localparam int EGF_DIM       = 8;
  localparam int ENC_SYM       = 4;
  localparam int ENC_MES_LEN   = 240;
  localparam int ENC_PAR_LEN   = 16;
  localparam int ENC_MES_BEATS = ENC_MES_LEN / ENC_SYM;
  localparam int ENC_PAR_BEATS = ENC_PAR_LEN / ENC_SYM;

  typedef logic [EGF_DIM-1:0] egf_sym_t;

  typedef enum logic {
    MES = 1'b0,
    PAR = 1'b1
  } enc_cwf_state_t;

  // Width of a counter that must reach max(a, b) - 1; never narrower than 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/enc_cw_formatter_if.sv
// -----------------------------------------------------------------------------
// enc_cw_if
// Bundles the message input, parity input and codeword output stream of the
// codeword formatter.
//   slave  modport : formatter side (consumes mes/par, produces out_*)
//   master modport : environment side (drives mes/par/out_ready)
//
// Handshake: an output beat transfers on a rising edge where out_valid and
// out_ready are both 1; while out_valid=1 and out_ready=0 the beat (data and
// flags) is held unchanged. A message beat is consumed on a rising edge where
// mes_valid=1 and con_stall=0; con_stall=1 means mes_data is not taken and the
// upstream must freeze. par_valid is a single-cycle pulse with no back-pressure.
// -----------------------------------------------------------------------------
interface enc_cw_if #(
  parameter int EGF_DIM     = encoder_pkg::EGF_DIM,
  parameter int ENC_SYM     = encoder_pkg::ENC_SYM,
  parameter int ENC_PAR_LEN = encoder_pkg::ENC_PAR_LEN
) ();

  logic [ENC_SYM*EGF_DIM-1:0]     mes_data;
  logic                           mes_valid;
  logic [ENC_PAR_LEN*EGF_DIM-1:0] par_data;
  logic                           par_valid;
  logic                           out_ready;
  logic                           con_stall;
  logic [ENC_SYM*EGF_DIM-1:0]     out_data;
  logic                           out_valid;
  logic                           out_sop;
  logic                           out_eop;
  logic                           ovf_err;

  modport slave (
    input  mes_data, mes_valid, par_data, par_valid, out_ready,
    output con_stall, out_data, out_valid, out_sop, out_eop, ovf_err
  );

  modport master (
    output mes_data, mes_valid, par_data, par_valid, out_ready,
    input  con_stall, out_data, out_valid, out_sop, out_eop, ovf_err
  );

endinterface

// File: rtl/enc_cw_formatter_par_shadow.sv
// -----------------------------------------------------------------------------
// enc_par_shadow
// Holds one finished parity block and shifts it out highest-order beat first.
//   clk, rst_n     clock / asynchronous active-low reset
//   par_data_i     finished parity (index ENC_PAR_LEN-1 = highest order)
//   par_valid_i    single-cycle load pulse
//   shift_i        consume the current head beat this cycle
//   last_i         the beat being consumed is the final parity beat
//   par_full_o     shadow holds parity not yet fully emitted
//   head_o         highest-order ENC_SYM symbols of the shadow
//   ovf_err_o      sticky: a load arrived while the shadow was still full
// -----------------------------------------------------------------------------
module enc_par_shadow #(
  parameter int EGF_DIM     = encoder_pkg::EGF_DIM,
  parameter int ENC_SYM     = encoder_pkg::ENC_SYM,
  parameter int ENC_PAR_LEN = encoder_pkg::ENC_PAR_LEN
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ENC_PAR_LEN*EGF_DIM-1:0] par_data_i,
  input  logic                           par_valid_i,
  input  logic                           shift_i,
  input  logic                           last_i,
  output logic                           par_full_o,
  output logic [ENC_SYM*EGF_DIM-1:0]     head_o,
  output logic                           ovf_err_o
);

  import encoder_pkg::*;

  localparam int BEAT_W = ENC_SYM * EGF_DIM;
  localparam int PAR_W  = ENC_PAR_LEN * EGF_DIM;

  logic [PAR_W-1:0] shadow_q, shadow_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             drain_done;

  // The final shift frees the shadow, so a load in the same cycle is accepted.
  assign drain_done = shift_i && last_i;

  always_comb begin
    shadow_d = shadow_q;
    full_d   = full_q;
    ovf_d    = ovf_q;
    if (shift_i) begin
      shadow_d = shadow_q << BEAT_W;
      if (last_i) begin
        full_d = 1'b0;
      end
    end
    if (par_valid_i) begin
      if (!full_q || drain_done) begin
        shadow_d = par_data_i;
        full_d   = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  assign par_full_o = full_q;
  assign head_o     = shadow_q[PAR_W-1 -: BEAT_W];
  assign ovf_err_o  = ovf_q;

endmodule

// File: rtl/enc_cw_formatter.sv
// -----------------------------------------------------------------------------
// enc_cw_formatter
// Assembles each systematic RS codeword onto one beat-wide stream: all message
// beats first, then the parity beats from the parity shadow.
//   clk, rst_n       clock / asynchronous active-low reset
//   bus (slave)      mes_data/mes_valid, par_data/par_valid, out_ready in;
//                    con_stall, out_data/out_valid/out_sop/out_eop, ovf_err out
//   dbg_state_o      current FSM state
//   dbg_beat_cnt_o   beat counter within the current section, zero-extended
// con_stall is combinational: the upstream is frozen whenever the formatter
// is in PAR or the output register cannot accept a new beat.
// -----------------------------------------------------------------------------
module enc_cw_formatter #(
  parameter int EGF_DIM     = encoder_pkg::EGF_DIM,
  parameter int ENC_SYM     = encoder_pkg::ENC_SYM,
  parameter int ENC_MES_LEN = encoder_pkg::ENC_MES_LEN,
  parameter int ENC_PAR_LEN = encoder_pkg::ENC_PAR_LEN
) (
  input  logic                        clk,
  input  logic                        rst_n,
  enc_cw_if.slave                     bus,
  output encoder_pkg::enc_cwf_state_t dbg_state_o,
  output logic [15:0]                 dbg_beat_cnt_o
);

  import encoder_pkg::*;

  localparam int BEAT_W    = ENC_SYM * EGF_DIM;
  localparam int MES_BEATS = ENC_MES_LEN / ENC_SYM;
  localparam int PAR_BEATS = ENC_PAR_LEN / ENC_SYM;
  localparam int CNT_W     = cnt_width(MES_BEATS, PAR_BEATS);

  localparam logic [CNT_W-1:0] MES_LAST = CNT_W'(MES_BEATS - 1);
  localparam logic [CNT_W-1:0] PAR_LAST = CNT_W'(PAR_BEATS - 1);

  enc_cwf_state_t    state_q;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic [BEAT_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              out_sop_q;
  logic              out_eop_q;

  logic              slot_free;
  logic              con_stall;
  logic              mes_take;
  logic              par_emit;
  logic              par_last;
  logic              par_full;
  logic [BEAT_W-1:0] par_head;
  logic              ovf_err;

  // The output register can take a new beat when empty or being drained now.
  assign slot_free = !out_valid_q || bus.out_ready;
  assign con_stall = !((state_q == MES) && slot_free);
  assign mes_take  = bus.mes_valid && !con_stall;
  assign par_emit  = (state_q == PAR) && slot_free && par_full;
  assign par_last  = (beat_cnt_q == PAR_LAST);

  enc_par_shadow #(
    .EGF_DIM     (EGF_DIM),
    .ENC_SYM     (ENC_SYM),
    .ENC_PAR_LEN (ENC_PAR_LEN)
  ) u_shadow (
    .clk         (clk),
    .rst_n       (rst_n),
    .par_data_i  (bus.par_data),
    .par_valid_i (bus.par_valid),
    .shift_i     (par_emit),
    .last_i      (par_last),
    .par_full_o  (par_full),
    .head_o      (par_head),
    .ovf_err_o   (ovf_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MES;
      beat_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      case (state_q)
        MES: begin
          if (mes_take) begin
            out_data_q  <= bus.mes_data;
            out_valid_q <= 1'b1;
            out_sop_q   <= (beat_cnt_q == '0);
            out_eop_q   <= 1'b0;
            if (beat_cnt_q == MES_LAST) begin
              beat_cnt_q <= '0;
              state_q    <= PAR;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end else if (slot_free) begin
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
          end
        end
        PAR: begin
          if (slot_free) begin
            if (par_full) begin
              out_data_q  <= par_head;
              out_valid_q <= 1'b1;
              out_sop_q   <= 1'b0;
              out_eop_q   <= par_last;
              if (par_last) begin
                beat_cnt_q <= '0;
                state_q    <= MES;
              end else begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
              end
            end else begin
              // Parity not ready yet: emit a bubble, keep position.
              out_valid_q <= 1'b0;
              out_sop_q   <= 1'b0;
              out_eop_q   <= 1'b0;
            end
          end
        end
        default: state_q <= MES;
      endcase
    end
  end

  assign bus.con_stall = con_stall;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.ovf_err   = ovf_err;

  assign dbg_state_o    = state_q;
  assign dbg_beat_cnt_o = 16'(beat_cnt_q);

endmodule
